// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, access-size codes and request error check for dmem_responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;
    function automatic logic req_err(input logic we, input logic [2:0] mode, input logic [1:0] lo, input logic oob);
        return oob || (mode inside {3'b011, 3'b110, 3'b111}) || (we && mode[2])
            || ((mode == MODE_H || mode == MODE_HU) && lo[0]) || (mode == MODE_W && lo != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the Memory stage and the data-memory responder
interface dmem_responder_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_mode;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;
    modport master (output req_valid, req_we, req_mode, req_addr, req_wdata,
                    input req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
    modport slave (input req_valid, req_we, req_mode, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// lsu_align: little-endian lane extraction with sign/zero extension for loads, lane replication and byte enables for stores
module lsu_align import dmem_pkg::*; #(parameter int WIDTH = 32) (
    input  logic [2:0]       mode,
    input  logic [1:0]       lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rword,
    output logic [WIDTH-1:0] ldata,
    output logic [WIDTH-1:0] wlane,
    output logic [3:0]       be
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rword[{lo, 3'b000} +: 8];
        h = rword[{lo[1], 4'b0000} +: 16];
        ldata = mode == MODE_B  ? {{(WIDTH-8){b[7]}}, b} :
                mode == MODE_H  ? {{(WIDTH-16){h[15]}}, h} :
                mode == MODE_BU ? {{(WIDTH-8){1'b0}}, b} :
                mode == MODE_HU ? {{(WIDTH-16){1'b0}}, h} : rword;
        wlane = mode == MODE_B ? {(WIDTH/8){wdata[7:0]}} :
                mode == MODE_H ? {(WIDTH/16){wdata[15:0]}} : wdata;
        be = mode == MODE_B ? 4'b0001 << lo :
             mode == MODE_H ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM answering one load/store at a time after LATENCY cycles
module dmem_responder import dmem_pkg::*; #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024,
    parameter int WIDTH   = 32
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             we_q, err_q, accept, enter_resp, c_we, c_err;
    logic [2:0]       mode_q, c_mode;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, c_addr, c_wdata, rword, ldata, wlane;
    logic [3:0]       be;
    logic [WIDTH-1:0] mem [DEPTH];
    assign accept = bus.req_valid && bus.req_ready;
    // With single-cycle latency the transaction enters RESP on its accept edge, before the latches hold it
    assign c_we    = LATENCY == 1 ? bus.req_we    : we_q;
    assign c_mode  = LATENCY == 1 ? bus.req_mode  : mode_q;
    assign c_addr  = LATENCY == 1 ? bus.req_addr  : addr_q;
    assign c_wdata = LATENCY == 1 ? bus.req_wdata : wdata_q;
    assign c_err   = req_err(c_we, c_mode, c_addr[1:0], c_addr >= WIDTH'(4 * DEPTH));
    assign rword   = mem[c_addr[AW+1:2]];
    assign enter_resp = !rst && state_nx == RESP;
    lsu_align #(.WIDTH(WIDTH)) u_align (
        .mode(c_mode), .lo(c_addr[1:0]), .wdata(c_wdata), .rword(rword),
        .ldata(ldata), .wlane(wlane), .be(be)
    );
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb
        state_nx = accept ? (LATENCY == 1 ? RESP : WAIT) :
                   state == RESP ? IDLE :
                   (state == WAIT && cnt == '0) ? RESP : state;
    always_comb begin
        bus.req_ready = state != WAIT;
        bus.rsp_valid = state == RESP;
        bus.busy      = state == WAIT;
        bus.rsp_rdata = state == RESP ? rdata_q : '0;
        bus.rsp_err   = state == RESP && err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_INIT;
                we_q    <= bus.req_we;
                mode_q  <= bus.req_mode;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                err_q   <= c_err;
                rdata_q <= (c_err || c_we) ? '0 : ldata;
            end
        end
    end
    always_ff @(posedge clk)
        if (enter_resp && c_we && !c_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory interface: accepts one load/store request at a time from the Memory stage, performs it against an internal word-organised RAM after a programmable wait-state latency, and returns read data plus a completion/error response. It replaces the zero-latency data memory so the pipeline's stall/handshake logic can be exercised against realistic memory timing. Sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- `LATENCY`, 2: cycles from request acceptance to response, ≥1
- `DEPTH`, 1024: RAM size in 32-bit words, power of two
- `WIDTH`, 32: data/address width
- `clk` input 1: clock, all state updates on rising edge
- `rst` input 1: reset; one clock, synchronous, active-high
- `req_valid` input 1: request present
- `req_ready` output 1: responder can accept this cycle
- `req_we` input 1: 1 = store, 0 = load
- `req_mode` input 3: RISC-V funct3 size/sign code
- `req_addr` input WIDTH: byte address
- `req_wdata` input WIDTH: store data, right-aligned
- `rsp_valid` output 1: one-cycle response pulse
- `rsp_rdata` output WIDTH: extended load data, 0 for stores/errors
- `rsp_err` output 1: request rejected, qualified by rsp_valid
- `busy` output 1: request outstanding, response not yet delivered

## Operation
- FSM states IDLE, WAIT, RESP. Reset → IDLE, cnt=0; outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- req_ready = (state==IDLE) || (state==RESP). Accept = req_valid && req_ready at clock edge; request fields latched.
- On accept: LATENCY==1 → RESP; else → WAIT with cnt=LATENCY-2, decrement each cycle, → RESP at cnt==0.
- RESP lasts one cycle, rsp_valid=1. If a new request is accepted in RESP → WAIT/RESP per above (back-to-back); else → IDLE.
- busy = state==WAIT, or state==RESP with no further request outstanding being 0 ⇒ busy=1 only in WAIT.
- Modes: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW. Little-endian lanes selected by addr[1:0].
- Loads: selected byte/half sign- or zero-extended to WIDTH.
- Stores: only addressed lanes written; others preserved. Write commits on the edge entering RESP.
- Errors (rsp_err=1, rdata=0, no write): misaligned half (addr[0]=1) or word (addr[1:0]≠0); addr ≥ 4·DEPTH; invalid mode (011, 110, 111; also 100/101 with req_we=1).
- RAM contents not affected by rst; initial contents all zero.

## Timing
- Accept at edge E → rsp_valid high in cycle after edge E+LATENCY-1 (i.e. visible LATENCY cycles after acceptance), for exactly one cycle.
- rsp_rdata/rsp_err driven only while rsp_valid; 0 otherwise.
- Load following store to same address (back-to-back) returns the new data: store commits before the load reads.
- Throughput: one request per LATENCY cycles with back-to-back issue.
- Request inputs ignored when req_ready=0; requester must hold them stable until accepted.
- rst mid-WAIT: transaction abandoned, no write commits, no rsp_valid; next cycle in IDLE.
- rst in RESP cycle: write already committed; FSM to IDLE, any same-cycle accept discarded.
- cnt width = clog2(LATENCY)+1; no wrap possible.

## Structure
- Package `dmem_pkg`: state enum (IDLE/WAIT/RESP), mode localparams (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU), error-check function.
- Sub-module `lsu_align`: combinational lane extraction/sign-extension for loads and byte-enable/data merge for stores; instantiated once.
- RAM as single array, one read port, one write port.

## Test plan
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid exactly 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
- SH 0x1234 @0x22, LH @0x22 → 0x00001234; LH @0x21 → rsp_err=1, rdata=0, word @0x20 unchanged.
- Back-to-back: req_valid held for 3 requests → accepts every 2 cycles, each response one-cycle, in order.
- LW @4·DEPTH → rsp_err=1; mode 011 → rsp_err=1; SB with mode 100 → err, no write.
- Store accepted, rst asserted during WAIT → no rsp_valid, subsequent LW of that address returns old value; LATENCY=1 variant: response on next cycle.
